// File: rtl/des_frame_ctrl_pkg.sv
// des_pkg: shared state encoding and sizing helpers for the deserializer framing path
package des_pkg;
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} des_state_t;
  function automatic int spw(input int n, input int m);
    return m / n;
  endfunction
  function automatic int cnt_w(input int x);
    return (x < 2) ? 1 : $clog2(x);
  endfunction
endpackage

// File: rtl/des_frame_ctrl_if.sv
// des_frame_ctrl_if: serial symbol input and payload word valid/ready bundle
interface des_frame_ctrl_if #(
  parameter int N = 1,
  parameter int M = 8
) ();
  logic         rx_valid;
  logic [N-1:0] rx;
  logic [M-1:0] word_data;
  logic         word_valid;
  logic         word_ready;
  logic         word_sof;
  modport master (output rx_valid, rx, word_ready, input word_data, word_valid, word_sof);
  modport slave  (input rx_valid, rx, word_ready, output word_data, word_valid, word_sof);
endinterface

// File: rtl/des_frame_ctrl_win.sv
// des_shift_win: M-bit symbol window, newest symbol enters at the MSB end
module des_shift_win #(
  parameter int N = 1,
  parameter int M = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         shift_i,
  input  logic         clr_i,
  input  logic [N-1:0] din_i,
  output logic [M-1:0] win_d_o,
  output logic [M-1:0] win_q_o
);
  logic [M-1:0] win_q;
  if (N == M) begin : g_full
    assign win_d_o = din_i;
  end else begin : g_part
    assign win_d_o = {din_i, win_q[M-1:N]};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) win_q <= '0;
    else if (clr_i) win_q <= '0;
    else if (shift_i) win_q <= win_d_o;
  assign win_q_o = win_q;
endmodule

// File: rtl/des_frame_ctrl.sv
// des_frame_ctrl: hunts for SYNC, verifies it on frame boundaries, then streams payload words
module des_frame_ctrl
  import des_pkg::*;
#(
  parameter int           N         = 1,
  parameter int           M         = 8,
  parameter logic [M-1:0] SYNC      = 8'hA5,
  parameter int           FRAME_LEN = 4,
  parameter int           LOCK_CNT  = 2,
  parameter int           LOSS_CNT  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_ovf_i,
  output logic locked_o,
  output logic ovf_o,
  des_frame_ctrl_if.slave bus
);
  localparam int SPW = spw(N, M);
  localparam int SW  = cnt_w(SPW);
  localparam int FW  = cnt_w(FRAME_LEN);
  localparam int GW  = cnt_w(LOCK_CNT + 1);
  localparam int MW  = cnt_w(LOSS_CNT + 1);
  if (M % N != 0) begin : g_bad_mn
    $error("M must be a multiple of N");
  end
  if (FRAME_LEN < 2 || LOCK_CNT < 1 || LOSS_CNT < 1) begin : g_bad_cnt
    $error("FRAME_LEN >= 2, LOCK_CNT >= 1 and LOSS_CNT >= 1 required");
  end
  des_state_t   state_q, state_d;
  logic [SW-1:0] sym_q, sym_d;
  logic [FW-1:0] slot_q, slot_d;
  logic [GW-1:0] good_q, good_d, good_inc;
  logic [MW-1:0] miss_q, miss_d, miss_inc;
  logic [M-1:0]  data_q, data_d, win_d, win_q;
  logic          valid_q, valid_d, sof_q, sof_d, ovf_q, ovf_d;
  logic          accept, done, match, slot0;
  assign accept   = en_i & bus.rx_valid;
  assign match    = win_d == SYNC;
  assign done     = accept && sym_q == SW'(SPW - 1);
  assign slot0    = slot_q == '0;
  assign good_inc = (int'(good_q) >= LOCK_CNT) ? good_q : good_q + 1'b1;
  assign miss_inc = (int'(miss_q) >= LOSS_CNT) ? miss_q : miss_q + 1'b1;
  des_shift_win #(.N(N), .M(M)) u_win (
    .clk     (clk),
    .rst     (rst),
    .shift_i (accept),
    .clr_i   (~en_i),
    .din_i   (bus.rx),
    .win_d_o (win_d),
    .win_q_o (win_q)
  );
  always_comb begin
    state_d = state_q;
    sym_d   = sym_q;
    slot_d  = slot_q;
    good_d  = good_q;
    miss_d  = miss_q;
    data_d  = data_q;
    sof_d   = sof_q;
    valid_d = valid_q & ~bus.word_ready;
    ovf_d   = ovf_q & ~clr_ovf_i;
    if (!en_i) begin
      state_d = HUNT;
      sym_d   = '0;
      slot_d  = '0;
      good_d  = '0;
      miss_d  = '0;
      valid_d = 1'b0;
      sof_d   = 1'b0;
    end else if (accept && state_q == HUNT) begin
      if (match) begin
        state_d = (LOCK_CNT == 1) ? LOCKED : VERIFY;
        sym_d   = '0;
        slot_d  = FW'(1);
        good_d  = GW'(1);
        miss_d  = '0;
      end
    end else if (accept) begin
      sym_d = done ? '0 : sym_q + 1'b1;
      if (done) begin
        slot_d = (slot_q == FW'(FRAME_LEN - 1)) ? '0 : slot_q + 1'b1;
        if (slot0 && state_q == VERIFY) begin
          good_d  = match ? good_inc : good_q;
          miss_d  = '0;
          state_d = !match ? HUNT : (int'(good_inc) >= LOCK_CNT) ? LOCKED : VERIFY;
        end else if (slot0) begin
          miss_d  = match ? '0 : miss_inc;
          state_d = (!match && int'(miss_inc) >= LOSS_CNT) ? HUNT : state_q;
        end else if (state_q == LOCKED) begin
          // a full holding register keeps its word; the newcomer is the one lost
          if (!valid_q || bus.word_ready) begin
            data_d  = win_d;
            valid_d = 1'b1;
            sof_d   = slot_q == FW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= HUNT;
      sym_q   <= '0;
      slot_q  <= '0;
      good_q  <= '0;
      miss_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      slot_q  <= slot_d;
      good_q  <= good_d;
      miss_q  <= miss_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      ovf_q   <= ovf_d;
    end
  assign locked_o       = state_q == LOCKED;
  assign ovf_o          = ovf_q;
  assign bus.word_data  = data_q;
  assign bus.word_valid = valid_q;
  assign bus.word_sof   = sof_q;
endmodule

// File: tb/tb_des_frame_ctrl.sv
// tb_des_frame_ctrl: randomized-gap and directed scenarios against a bit-stream framing model
module tb_des_frame_ctrl;
  localparam int FL = 4, LOCK = 2, LOSS = 2;
  logic clk = 1'b0, rst, en, clr_ovf, locked, ovf;
  des_frame_ctrl_if #(.N(1), .M(8)) bus ();
  des_frame_ctrl #(.N(1), .M(8), .SYNC(8'hA5), .FRAME_LEN(FL), .LOCK_CNT(LOCK), .LOSS_CNT(LOSS)) dut (
    .clk       (clk),
    .rst       (rst),
    .en_i      (en),
    .clr_ovf_i (clr_ovf),
    .locked_o  (locked),
    .ovf_o     (ovf),
    .bus       (bus.slave)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  int m_st, m_pos, m_good, m_miss;
  logic [7:0] m_hist;
  logic [8:0] exp_q[$];
  logic [7:0] s1[10] = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'hA5, 8'h44, 8'h55, 8'h66, 8'hA5, 8'h77};
  logic [7:0] s2[6]  = '{8'h3C, 8'hA5, 8'h12, 8'h34, 8'h56, 8'h00};
  logic [7:0] s4[24] = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'hA5, 8'h44, 8'h55, 8'h66,
                         8'h00, 8'h77, 8'h88, 8'h99, 8'hA5, 8'hAA, 8'hBB, 8'hCC,
                         8'h00, 8'hDD, 8'hEE, 8'hFF, 8'h00, 8'h12, 8'h34, 8'h56};

  task automatic model_reset();
    m_st = 0; m_pos = 0; m_good = 0; m_miss = 0; m_hist = 8'h00;
    exp_q.delete();
  endtask

  // model: m_pos counts bits since the end of the sync that started the frame
  task automatic model_bit(input logic b);
    int slot;
    bit hit;
    m_hist = 8'((int'(m_hist) >> 1) | (int'(b) << 7));
    hit = m_hist == 8'hA5;
    if (m_st == 0) begin
      if (hit) begin
        m_st = (LOCK == 1) ? 2 : 1; m_pos = 0; m_good = 1; m_miss = 0;
      end
      return;
    end
    m_pos++;
    if (m_pos % 8 != 0) return;
    slot = (m_pos / 8) % FL;
    if (slot == 0 && m_st == 1) begin
      if (hit) begin
        m_good++;
        if (m_good >= LOCK) begin m_st = 2; m_miss = 0; end
      end else m_st = 0;
    end else if (slot == 0) begin
      if (hit) m_miss = 0;
      else begin
        m_miss++;
        if (m_miss >= LOSS) m_st = 0;
      end
    end else if (m_st == 2) exp_q.push_back({slot == 1, m_hist});
  endtask

  task automatic cyc(input logic v, input logic b);
    logic [8:0] e;
    bus.rx_valid = v;
    bus.rx = b;
    if (bus.word_valid && bus.word_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL word: got unexpected data=%h sof=%b, required none", bus.word_data, bus.word_sof);
      end else begin
        e = exp_q.pop_front();
        if ({bus.word_sof, bus.word_data} !== e) begin
          n_bad++;
          $display("FAIL word: got data=%h sof=%b, required data=%h sof=%b", bus.word_data, bus.word_sof, e[7:0], e[8]);
        end
      end
    end
    @(posedge clk);
    if (v && en) model_bit(b);
    @(negedge clk);
    n_cmp++;
    if (locked !== (m_st == 2)) begin
      n_bad++;
      $display("FAIL locked: got %b, required %b", locked, m_st == 2);
    end
  endtask

  task automatic send(input logic [7:0] byt, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) cyc(1'b0, 1'b0);
      cyc(1'b1, byt[i]);
    end
  endtask

  task automatic drain();
    repeat (4) cyc(1'b0, 1'b0);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d words still expected, required 0", exp_q.size());
    end
  endtask

  task automatic raw_byte(input logic [7:0] byt, input logic clr_last, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx = byt[i];
      clr_ovf = clr_last && i == 7;
      @(posedge clk);
      @(negedge clk);
    end
    bus.rx_valid = 1'b0;
    clr_ovf = 1'b0;
  endtask

  task automatic idle(input logic clr);
    bus.rx_valid = 1'b0;
    clr_ovf = clr;
    @(posedge clk);
    @(negedge clk);
    clr_ovf = 1'b0;
  endtask

  task automatic do_reset();
    bus.rx_valid = 1'b0; bus.rx = 1'b0; bus.word_ready = 1'b1;
    en = 1'b1; clr_ovf = 1'b0; rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic check_out(input string nm, input logic [7:0] d, input logic v, input logic s,
                           input logic l, input logic o);
    n_cmp++;
    if ({bus.word_data, bus.word_valid, bus.word_sof, locked, ovf} !== {d, v, s, l, o}) begin
      n_bad++;
      $display("FAIL %s: got data=%h valid=%b sof=%b locked=%b ovf=%b, required data=%h valid=%b sof=%b locked=%b ovf=%b",
               nm, bus.word_data, bus.word_valid, bus.word_sof, locked, ovf, d, v, s, l, o);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_out("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_acquire();
    do_reset();
    foreach (s1[i]) send(s1[i], 1'b0);
    drain();
    check_out("acquire_end", 8'h77, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_false_sync();
    do_reset();
    foreach (s2[i]) send(s2[i], 1'b0);
    drain();
    check_out("false_sync", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 5; i++) send(s1[i], 1'b0);
    bus.word_ready = 1'b0;
    raw_byte(8'h44, 1'b0, 8);
    check_out("bp_hold44", 8'h44, 1'b1, 1'b1, 1'b1, 1'b0);
    raw_byte(8'h55, 1'b0, 8);
    check_out("bp_drop55", 8'h44, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(1'b1);
    check_out("bp_clr", 8'h44, 1'b1, 1'b1, 1'b1, 1'b0);
    raw_byte(8'h66, 1'b1, 8);
    check_out("bp_set_wins", 8'h44, 1'b1, 1'b1, 1'b1, 1'b1);
    bus.word_ready = 1'b1;
    idle(1'b0);
    check_out("bp_handshake", 8'h44, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(1'b1);
    check_out("bp_clr2", 8'h44, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_loss();
    do_reset();
    foreach (s4[i]) send(s4[i], 1'b0);
    drain();
    n_cmp++;
    if (locked !== 1'b0) begin
      n_bad++;
      $display("FAIL loss_end: got locked=%b, required 0", locked);
    end
  endtask

  task automatic test_gaps();
    for (int r = 0; r < 3; r++) begin
      do_reset();
      foreach (s1[i]) send(s1[i], 1'b1);
      drain();
    end
  endtask

  task automatic test_mid_word();
    logic [7:0] b55 = 8'h55;
    do_reset();
    for (int i = 0; i < 6; i++) send(s1[i], 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, b55[i]);
    rst = 1'b1;
    #1;
    check_out("mid_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    foreach (s1[i]) send(s1[i], 1'b0);
    drain();
    do_reset();
    for (int i = 0; i < 5; i++) send(s1[i], 1'b0);
    bus.word_ready = 1'b0;
    raw_byte(8'h44, 1'b0, 8);
    raw_byte(8'h55, 1'b0, 8);
    raw_byte(8'h66, 1'b0, 3);
    en = 1'b0;
    idle(1'b0);
    check_out("mid_en", 8'h44, 1'b0, 1'b0, 1'b0, 1'b1);
    en = 1'b1;
    bus.word_ready = 1'b1;
    model_reset();
    foreach (s1[i]) send(s1[i], 1'b0);
    drain();
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; clr_ovf = 1'b0;
    bus.rx_valid = 1'b0; bus.rx = 1'b0; bus.word_ready = 1'b1;
    model_reset();
    @(negedge clk);
    test_reset();
    test_acquire();
    test_false_sync();
    test_backpressure();
    test_loss();
    test_gaps();
    test_mid_word();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
